// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: one outstanding memory read feeding a 2-entry
// {instr, pc_next} queue toward decode, with redirect, halt and error handling.
module fetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        imem_err,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] instr,
  output logic [15:0] pc_next,
  output logic        if_valid,
  output logic        nop_mech,
  output logic        idf_err,
  output logic        halted
);

  typedef enum logic [1:0] {S_REQ, S_IDLE, S_DRAIN, S_HALT} state_t;

  state_t      state, st_n;
  logic [15:0] pc, pc_n, addr_n, iss_pc;
  logic [1:0]  count, cnt_free, iss_cnt;
  logic        rd_n, err_n, flush, push, do_issue, consume;
  logic        rd_ptr, wr_ptr;
  logic [15:0] fifo_instr [2];
  logic [15:0] fifo_pcn   [2];

  assign if_valid = (count != 2'd0);
  assign nop_mech = ~if_valid;
  assign instr    = if_valid ? fifo_instr[rd_ptr] : 16'h0800;
  assign pc_next  = if_valid ? fifo_pcn[rd_ptr]   : 16'h0000;
  assign halted   = (state == S_HALT);
  assign consume  = if_valid & ~stall_in;
  assign cnt_free = count - {1'b0, consume};

  always_comb begin
    st_n     = state;
    rd_n     = imem_rd;
    addr_n   = imem_addr;
    pc_n     = pc;
    err_n    = idf_err;
    flush    = 1'b0;
    push     = 1'b0;
    do_issue = 1'b0;
    iss_pc   = pc;
    iss_cnt  = cnt_free;
    if (idf_err) begin
      // An error locks the block in HALT until reset.
      st_n = S_HALT;
      rd_n = 1'b0;
    end else if (redirect) begin
      flush = 1'b0 | 1'b1;
      pc_n  = redirect_pc;
      if (imem_rd && !imem_done) begin
        st_n = S_DRAIN;
      end else begin
        do_issue = 1'b1;
        iss_pc   = redirect_pc;
        iss_cnt  = 2'd0;
      end
    end else begin
      case (state)
        S_REQ: begin
          if (!imem_rd) begin
            do_issue = 1'b1;
          end else if (imem_done) begin
            if (imem_err) begin
              err_n = 1'b1;
              flush = 1'b1;
              st_n  = S_HALT;
              rd_n  = 1'b0;
            end else begin
              push = 1'b1;
              pc_n = pc + 16'd2;
              if (imem_rdata[15:11] == 5'b00000) begin
                st_n = S_HALT;
                rd_n = 1'b0;
              end else begin
                do_issue = 1'b1;
                iss_pc   = pc + 16'd2;
                iss_cnt  = cnt_free + 2'd1;
              end
            end
          end
        end
        S_IDLE:  if (consume) do_issue = 1'b1;
        // Stale data returning after a redirect is dropped, errors included.
        S_DRAIN: if (imem_done) begin
          do_issue = 1'b1;
          iss_cnt  = 2'd0;
        end
        default: rd_n = 1'b0;
      endcase
    end
    if (do_issue) begin
      if (iss_pc[0]) begin
        err_n = 1'b1;
        flush = 1'b1;
        st_n  = S_HALT;
        rd_n  = 1'b0;
      end else if (iss_cnt < 2'd2) begin
        st_n   = S_REQ;
        rd_n   = 1'b1;
        addr_n = iss_pc;
      end else begin
        st_n = S_IDLE;
        rd_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= 16'h0000;
      imem_rd   <= 1'b0;
      imem_addr <= 16'h0000;
      idf_err   <= 1'b0;
      count     <= 2'd0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
    end else begin
      state     <= st_n;
      pc        <= pc_n;
      imem_rd   <= rd_n;
      imem_addr <= addr_n;
      idf_err   <= err_n;
      if (flush) begin
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        count <= count + {1'b0, push} - {1'b0, consume};
        if (push)    wr_ptr <= ~wr_ptr;
        if (consume) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Queue payload carries no reset; the output mux masks it while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata;
      fifo_pcn[wr_ptr]   <= pc + 16'd2;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic, all checked
// against a stream-level model of fetched/consumed instructions.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_rd, imem_done, imem_err;
  logic [15:0] imem_addr, imem_rdata;
  logic        stall_in, redirect;
  logic [15:0] redirect_pc;
  logic [15:0] instr, pc_next;
  logic        if_valid, nop_mech, idf_err, halted;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_rd(imem_rd), .imem_addr(imem_addr),
    .imem_done(imem_done), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .stall_in(stall_in), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .pc_next(pc_next), .if_valid(if_valid), .nop_mech(nop_mech),
    .idf_err(idf_err), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pcn;
  } ent_t;

  // Reference model: the words decode should see, in order, plus fetch-side state.
  ent_t        q[$];
  logic [15:0] fetch_pc, stale_addr;
  bit          stale, halted_m, err_m, post_rst;
  bit          mem_busy, rand_mode;
  int          mem_wait, lat_force, halt_at;

  task automatic model_reset();
    q.delete();
    fetch_pc = 16'h0000;
    stale    = 1'b0;
    halted_m = 1'b0;
    err_m    = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic check_outputs();
    int n;
    logic [15:0] e_ins, e_pcn;
    n = q.size();
    e_ins = 16'h0800;
    e_pcn = 16'h0000;
    if (n != 0) begin
      e_ins = q[0].ins;
      e_pcn = q[0].pcn;
    end
    chk("if_valid", if_valid, n != 0);
    chk("nop_mech", nop_mech, n == 0);
    chk("instr", instr, e_ins);
    chk("pc_next", pc_next, e_pcn);
    chk("halted", halted, halted_m);
    chk("idf_err", idf_err, err_m);
    if (post_rst) chk("rd_after_rst", imem_rd, 1'b0);
    else          chk("imem_rd", imem_rd, !halted_m && n < 2);
    if (imem_rd) chk("imem_addr", imem_addr, stale ? stale_addr : fetch_pc);
  endtask

  task automatic update_model();
    bit   cons;
    ent_t e;
    cons = (q.size() != 0) && !stall_in;
    post_rst = 1'b0;
    if (err_m) return;
    if (redirect) begin
      q.delete();
      fetch_pc = redirect_pc;
      halted_m = 1'b0;
      if (imem_rd && !imem_done) begin
        stale = 1'b1;
        stale_addr = imem_addr;
      end else begin
        stale = 1'b0;
        if (redirect_pc[0]) begin
          err_m = 1'b1;
          halted_m = 1'b1;
        end
      end
    end else begin
      if (cons) void'(q.pop_front());
      if (imem_rd && imem_done) begin
        if (stale) begin
          stale = 1'b0;
          if (fetch_pc[0]) begin
            err_m = 1'b1;
            halted_m = 1'b1;
          end
        end else if (imem_err) begin
          err_m = 1'b1;
          halted_m = 1'b1;
          q.delete();
        end else begin
          e.ins = imem_rdata;
          e.pcn = fetch_pc + 16'd2;
          q.push_back(e);
          fetch_pc = fetch_pc + 16'd2;
          if (imem_rdata[15:11] == 5'b00000) halted_m = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit st, input bit rdir, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    stall_in    = st;
    redirect    = rdir;
    redirect_pc = rpc;
    imem_done   = 1'b0;
    imem_err    = 1'b0;
    imem_rdata  = 16'($urandom);
    if (imem_rd) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_wait = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
      end
      if (mem_wait == 0) begin
        imem_done = 1'b1;
        mem_busy  = 1'b0;
      end else begin
        mem_wait--;
      end
      if (!rand_mode) imem_rdata[15] = 1'b1;
      if (halt_at >= 0 && {16'h0000, imem_addr} == halt_at) imem_rdata = 16'h0000;
      if (rand_mode && $urandom_range(0, 299) == 0) imem_err = 1'b1;
    end else begin
      mem_busy = 1'b0;
      if (rand_mode && $urandom_range(0, 7) == 0) begin
        imem_done = 1'b1;
        imem_err  = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    check_outputs();
    update_model();
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    stall_in    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    imem_done   = 1'b1;
    imem_err    = 1'b0;
    imem_rdata  = 16'h0000;
    model_reset();
    #1;
    chk("rst_imem_rd", imem_rd, 1'b0);
    chk("rst_imem_addr", imem_addr, 16'h0000);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_pc_next", pc_next, 16'h0000);
    chk("rst_if_valid", if_valid, 1'b0);
    chk("rst_nop_mech", nop_mech, 1'b1);
    chk("rst_idf_err", idf_err, 1'b0);
    chk("rst_halted", halted, 1'b0);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    post_rst = 1'b1;
    // A late completion (and a halt word) right after release must be ignored.
    imem_done  = 1'b1;
    imem_rdata = 16'h0000;
    @(negedge clk);
    check_outputs();
    update_model();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held, old_addr;
    bit found;
    int r;
    logic [15:0] rpc;
    stall_in = 0; redirect = 0; redirect_pc = 0;
    imem_done = 0; imem_err = 0; imem_rdata = 0;
    rand_mode = 0; lat_force = 0; halt_at = -1; post_rst = 0;
    model_reset();

    // Single-cycle memory streaming from reset.
    do_reset(2);
    step(0, 0, 0);
    chk("d1_rd", imem_rd, 1'b1);
    chk("d1_addr", imem_addr, 16'h0000);
    step(0, 0, 0); chk("d1_pcn2", {if_valid, pc_next}, {1'b1, 16'h0002});
    step(0, 0, 0); chk("d1_pcn4", {if_valid, pc_next}, {1'b1, 16'h0004});
    step(0, 0, 0); chk("d1_pcn6", {if_valid, pc_next}, {1'b1, 16'h0006});

    // Three stalled cycles fill the queue and stop reads; order survives.
    step(1, 0, 0);
    held = pc_next;
    step(1, 0, 0); chk("d2_hold1", pc_next, held);
    step(1, 0, 0); chk("d2_hold2", pc_next, held);
    chk("d2_full_no_rd", imem_rd, 1'b0);
    step(0, 0, 0); chk("d2_rel0", pc_next, held);
    step(0, 0, 0); chk("d2_rel1", pc_next, held + 16'd2);
    step(0, 0, 0); chk("d2_rel2", pc_next, held + 16'd4);

    // Redirect during a long read at 0x0008 drains the stale word.
    do_reset(1);
    lat_force = 3;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 0);
      if (imem_rd && imem_addr == 16'h0008 && mem_busy && mem_wait >= 1) found = 1;
    end
    chk("d3_reach_0008", found, 1'b1);
    old_addr = imem_addr;
    step(0, 1, 16'h0040);
    step(0, 0, 0);
    chk("d3_drain_addr", {imem_rd, imem_addr}, {1'b1, old_addr});
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0);
      if (if_valid) found = 1;
    end
    chk("d3_valid", found, 1'b1);
    chk("d3_pcn", pc_next, 16'h0042);

    // Halt word at 0x0006, then redirect restarts fetch.
    lat_force = 0;
    halt_at = 6;
    do_reset(1);
    repeat (8) step(0, 0, 0);
    chk("d4_halted", halted, 1'b1);
    chk("d4_no_rd", imem_rd, 1'b0);
    halt_at = -1;
    step(0, 1, 16'h0010);
    step(0, 0, 0);
    chk("d4_resume", {imem_rd, imem_addr, halted}, {1'b1, 16'h0010, 1'b0});

    // Misaligned redirect is a sticky error.
    step(0, 1, 16'h0011);
    step(0, 0, 0);
    chk("d5_err", {imem_rd, idf_err, halted}, {1'b0, 1'b1, 1'b1});
    step(0, 1, 16'h0020);
    step(0, 0, 0);
    chk("d5_locked", {imem_rd, idf_err, halted}, {1'b0, 1'b1, 1'b1});

    // Redirect in the same cycle as a completion.
    do_reset(1);
    repeat (3) step(0, 0, 0);
    chk("d6_rd_done", {imem_rd, imem_done}, 2'b11);
    step(0, 1, 16'h0080);
    chk("d6_coincident", {imem_rd, imem_done}, 2'b11);
    step(0, 0, 0);
    chk("d6_next_addr", {imem_rd, imem_addr}, {1'b1, 16'h0080});
    step(0, 0, 0);
    chk("d6_pcn", {if_valid, pc_next}, {1'b1, 16'h0082});

    // Randomized traffic with occasional resets.
    rand_mode = 1;
    lat_force = -1;
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        r = $urandom_range(0, 19);
        rpc = 16'($urandom) & 16'hFFFE;
        if (r == 0) rpc = rpc | 16'h0001;
        else if (r < 3) rpc = 16'hFFFC;
        step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, rpc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
